// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP word, PC step and
// the redirect-target alignment helper.
package fetch_unit_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_FULL  = 2'd2;
  localparam fetch_state_t ST_DROP  = 2'd3;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a one-entry skid
// buffer for stalls, and a DROP state that swallows a request orphaned by a branch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] addr_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_addr_q, buf_addr_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_next;

  assign pc_next = pc_q + PC_INCR;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    buf_inst_d = buf_inst_q;
    buf_addr_d = buf_addr_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    valid_d    = valid_q;

    // Unless a new instruction is presented, an unstalled cycle shows a bubble.
    if (!stall_i) begin
      addr_d  = 32'h0;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack_i) begin
          pc_d = pc_next;
          if (stall_i) begin
            buf_inst_d = imem_data_i;
            buf_addr_d = pc_next;
            state_d    = ST_FULL;
          end else begin
            addr_d  = pc_next;
            inst_d  = imem_data_i;
            valid_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (!stall_i) begin
          addr_d  = buf_addr_q;
          inst_d  = buf_inst_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem_ack_i) begin
          pc_d    = tgt_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides stall and ack; a still-pending request must be drained first.
    if (branch_i) begin
      addr_d     = 32'h0;
      inst_d     = NOP_WORD;
      valid_d    = 1'b0;
      buf_inst_d = NOP_WORD;
      buf_addr_d = 32'h0;
      if ((state_q == ST_FETCH || state_q == ST_DROP) && !imem_ack_i) begin
        tgt_d   = word_align(branch_addr_i);
        state_d = ST_DROP;
      end else begin
        pc_d    = word_align(branch_addr_i);
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= RESET_PC;
      buf_inst_q <= NOP_WORD;
      buf_addr_q <= 32'h0;
      addr_q     <= 32'h0;
      inst_q     <= NOP_WORD;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      buf_inst_q <= buf_inst_d;
      buf_addr_q <= buf_addr_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr_o = pc_q;
  assign addr_o      = addr_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;

endmodule
